ps2_frame_rx: RTL
=================

// Module: ps2_frame_rx
// PURPOSE
//  Front end of the PS/2 keyboard path: synchronises and deglitches the raw key_clk/key_din
//  lines, frames 11-bit PS/2 packets (start, 8 data LSB-first, odd parity, stop) and
//  delivers each validated scancode with a one-cycle strobe to the scancode-to-ASCII
//  translation stage. Adds parity/stop checking and inter-bit timeout recovery.
// PARAMETERS
//  SYNC_STAGES     2      synchroniser flops on key_clk and key_din (>=2)
//  FILTER_LEN      8      consecutive equal samples needed before filtered clock changes (>=1)
//  TIMEOUT_CYCLES  25000  max clk cycles between bit edges inside a frame (1 ms @ 25 MHz)
// PORTS
//  clk         in   1  system clock (25 MHz)
//  rst         in   1  synchronous, active-high reset
//  key_clk     in   1  raw PS/2 clock from device (asynchronous)
//  key_din     in   1  raw PS/2 data from device (asynchronous)
//  scancode    out  8  last valid scancode; held until the next valid frame
//  scan_valid  out  1  one-cycle pulse: scancode updated this cycle
//  parity_err  out  1  one-cycle pulse: frame dropped, bad odd parity
//  frame_err   out  1  one-cycle pulse: frame dropped, stop bit 0 or timeout
//  busy        out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): sync chains and filtered clock = 1, filter count = 0,
//   state = IDLE, bit count = 0, timeout count = 0, scancode = 8'h00, all pulses = 0, busy = 0.
//   rst mid-frame discards the partial frame with no error pulse.
//  Sync: key_clk/key_din each pass SYNC_STAGES flops -> sclk, sdin.
//  Filter: fclk register; counter increments while sclk != fclk, clears when equal; when it
//   reaches FILTER_LEN-1 with sclk still != fclk, fclk <= sclk and counter clears.
//   Glitches shorter than FILTER_LEN cycles never reach fclk.
//  Edge: fall = fclk_prev & ~fclk; data sampled = sdin in the fall cycle.
//  FSM (advances only on fall, except timeout):
//   IDLE:   din=0 -> DATA, bitcnt=0, timeout count=0; din=1 -> stay IDLE, no pulse.
//   DATA:   shift din into bit[bitcnt] (LSB first); after 8th bit -> PARITY.
//   PARITY: store p; parity_ok = ^{data,p} == 1 (odd) -> STOP.
//   STOP:   -> IDLE always. din=0 -> frame_err; else !parity_ok -> parity_err;
//           else scancode<=data, scan_valid. Stop error takes precedence over parity error.
//  Timeout: in DATA/PARITY/STOP the counter increments every cycle and clears on each fall;
//   reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, partial data discarded. A fall and
//   timeout in the same cycle: the fall wins (counter clears, FSM advances).
//  Outputs registered; pulses assert the cycle after the STOP-bit fall, exactly one cycle.
//   Latency raw key_clk fall (stop bit) -> scan_valid = SYNC_STAGES+FILTER_LEN+1 cycles.
//  Back-to-back frames: IDLE accepts a new start bit on the first fall after returning;
//   no dead time beyond filter latency. Pulses never overlap (mutually exclusive).
//  Counter widths: filter = clog2(FILTER_LEN)+1, timeout = clog2(TIMEOUT_CYCLES)+1; no wrap.
// TESTING
//  1. Send 0x1C frame (start0, 00111000 LSB-first, parity 0, stop1), 80 us bit period ->
//     one scan_valid pulse, scancode=8'h1C, no error pulses, busy low afterwards.
//  2. Send 0xF0 then 0x1C back-to-back -> two scan_valid pulses, scancode 8'hF0 then 8'h1C.
//  3. Send 0x1C with parity bit flipped to 1 -> parity_err pulse once, scancode unchanged.
//  4. Send frame with stop bit 0 and bad parity -> frame_err only, no parity_err/scan_valid.
//  5. Stop key_clk after 4 data bits -> frame_err exactly TIMEOUT_CYCLES-1 cycles after last
//     fall, busy drops; following good 0x5A frame -> scan_valid, scancode=8'h5A.
//  6. Inject 3-cycle low glitches on key_clk between bits, and assert rst mid-frame ->
//     glitches ignored (correct code received); after rst all outputs at reset values,
//     no error pulse, next frame decodes correctly.

Source files
------------

// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver bus: raw device lines in, framed scancode and status out.
// master drives the key lines; slave is the receiver.
interface ps2_frame_rx_if;
  logic       key_clk;
  logic       key_din;
  logic [7:0] scancode;
  logic       scan_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output key_clk,
    output key_din,
    input  scancode,
    input  scan_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  key_clk,
    input  key_din,
    output scancode,
    output scan_valid,
    output parity_err,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: sync + deglitch of key_clk/key_din, 11-bit
// framing with odd parity, stop check and inter-bit timeout.
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_frame_rx_if.slave  bus
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] kc_q;
  logic [SYNC_STAGES-1:0] kd_q;
  logic                   sclk;
  logic                   sdin;

  logic                   fclk_q;
  logic                   fclk_d;
  logic [FW-1:0]          fcnt_q;
  logic [FW-1:0]          fcnt_d;
  logic                   fprev_q;
  logic                   fall;

  state_t                 state_q;
  logic [2:0]             bcnt_q;
  logic [TW-1:0]          tmo_q;
  logic [TW-1:0]          tmo_d;
  logic [7:0]             data_q;
  logic                   pok_q;
  logic [7:0]             code_q;
  logic                   sv_q;
  logic                   pe_q;
  logic                   fe_q;

  assign sclk = kc_q[SYNC_STAGES-1];
  assign sdin = kd_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      kc_q <= '1;
      kd_q <= '1;
    end else begin
      kc_q <= {kc_q[SYNC_STAGES-2:0], bus.key_clk};
      kd_q <= {kd_q[SYNC_STAGES-2:0], bus.key_din};
    end
  end

  // fclk follows sclk only after FILTER_LEN cycles of disagreement
  always_comb begin
    fclk_d = fclk_q;
    fcnt_d = '0;
    if (sclk != fclk_q) begin
      if (fcnt_q == FLAST) begin
        fclk_d = sclk;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fclk_q  <= 1'b1;
      fcnt_q  <= '0;
      fprev_q <= 1'b1;
    end else begin
      fclk_q  <= fclk_d;
      fcnt_q  <= fcnt_d;
      fprev_q <= fclk_q;
    end
  end

  assign fall  = fprev_q & ~fclk_q;
  assign tmo_d = tmo_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      pok_q   <= 1'b0;
      code_q  <= 8'h00;
      sv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      if (state_q == S_IDLE) begin
        tmo_q <= '0;
        if (fall && !sdin) begin
          state_q <= S_DATA;
          bcnt_q  <= '0;
        end
      end else if (fall) begin
        tmo_q <= '0;
        unique case (1'b1)
          (state_q == S_DATA): begin
            data_q[bcnt_q] <= sdin;
            bcnt_q         <= bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) begin
              state_q <= S_PAR;
            end
          end
          (state_q == S_PAR): begin
            pok_q   <= ^{data_q, sdin};
            state_q <= S_STOP;
          end
          default: begin
            state_q <= S_IDLE;
            if (!sdin) begin
              fe_q <= 1'b1;
            end else if (!pok_q) begin
              pe_q <= 1'b1;
            end else begin
              code_q <= data_q;
              sv_q   <= 1'b1;
            end
          end
        endcase
      end else if (tmo_d == TLAST) begin
        // stalled device: drop the partial frame
        state_q <= S_IDLE;
        tmo_q   <= '0;
        fe_q    <= 1'b1;
      end else begin
        tmo_q <= tmo_d;
      end
    end
  end

  assign bus.scancode   = code_q;
  assign bus.scan_valid = sv_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
